// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: an in-order FIFO of fetched words
// with PC and fault/progbuf flags. It empties in one cycle on a flush.
module instr_queue #(
  parameter int unsigned RISCV_ARCH = 64,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_flush,
  input  logic                  i_f_valid,
  output logic                  o_f_ready,
  input  logic [RISCV_ARCH-1:0] i_f_pc,
  input  logic [31:0]           i_f_instr,
  input  logic                  i_f_load_fault,
  input  logic                  i_f_page_fault_x,
  input  logic                  i_f_progbuf_ena,
  output logic                  o_d_valid,
  input  logic                  i_d_ready,
  output logic [RISCV_ARCH-1:0] o_d_pc,
  output logic [31:0]           o_d_instr,
  output logic                  o_d_load_fault,
  output logic                  o_d_page_fault_x,
  output logic                  o_d_progbuf_ena,
  output logic                  o_d_compressed
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [RISCV_ARCH-1:0] pc;
    logic [31:0]           instr;
    logic                  load_fault;
    logic                  page_fault_x;
    logic                  progbuf_ena;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // Ready is a function of occupancy only, so a full queue never accepts during a pop.
  assign o_f_ready = (r_count != CNT_W'(DEPTH));
  assign o_d_valid = (r_count != CNT_W'(0));
  assign w_push    = i_f_valid & o_f_ready;
  assign w_pop     = o_d_valid & i_d_ready;

  assign w_head           = r_mem[r_rd_ptr];
  assign o_d_pc           = w_head.pc;
  assign o_d_instr        = w_head.instr;
  assign o_d_load_fault   = w_head.load_fault;
  assign o_d_page_fault_x = w_head.page_fault_x;
  assign o_d_progbuf_ena  = w_head.progbuf_ena;
  assign o_d_compressed   = (w_head.instr[1:0] != 2'b11);

  // Storage: flush leaves contents untouched, it only suppresses the write.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i].pc           <= '1;
        r_mem[i].instr        <= '1;
        r_mem[i].load_fault   <= 1'b0;
        r_mem[i].page_fault_x <= 1'b0;
        r_mem[i].progbuf_ena  <= 1'b0;
      end
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr].pc           <= i_f_pc;
      r_mem[r_wr_ptr].instr        <= i_f_instr;
      r_mem[r_wr_ptr].load_fault   <= i_f_load_fault;
      r_mem[r_wr_ptr].page_fault_x <= i_f_page_fault_x;
      r_mem[r_wr_ptr].progbuf_ena  <= i_f_progbuf_ena;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Randomized and directed bench for instr_queue against a queue-based reference model.
module tb_instr_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            lf;
    logic            pf;
    logic            pb;
  } ent_t;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [31:0]     f_instr;
  logic            f_lf;
  logic            f_pf;
  logic            f_pb;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_pc;
  logic [31:0]     d_instr;
  logic            d_lf;
  logic            d_pf;
  logic            d_pb;
  logic            d_comp;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_queue #(.RISCV_ARCH(XLEN), .DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_nrst           (rst_n),
    .i_flush          (flush),
    .i_f_valid        (f_valid),
    .o_f_ready        (f_ready),
    .i_f_pc           (f_pc),
    .i_f_instr        (f_instr),
    .i_f_load_fault   (f_lf),
    .i_f_page_fault_x (f_pf),
    .i_f_progbuf_ena  (f_pb),
    .o_d_valid        (d_valid),
    .i_d_ready        (d_ready),
    .o_d_pc           (d_pc),
    .o_d_instr        (d_instr),
    .o_d_load_fault   (d_lf),
    .o_d_page_fault_x (d_pf),
    .o_d_progbuf_ena  (d_pb),
    .o_d_compressed   (d_comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] ins,
                        input logic lf, input logic pf, input logic pb,
                        input logic rdy, input logic fl);
    f_valid = v;  f_pc = pc;  f_instr = ins;
    f_lf = lf;    f_pf = pf;  f_pb = pb;
    d_ready = rdy;
    flush = fl;
  endtask

  task automatic check_outputs();
    chk("d_valid", 64'(d_valid), 64'(q.size() != 0));
    chk("f_ready", 64'(f_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      chk("d_pc",    d_pc,           q[0].pc);
      chk("d_instr", 64'(d_instr),   64'(q[0].instr));
      chk("d_lf",    64'(d_lf),      64'(q[0].lf));
      chk("d_pf",    64'(d_pf),      64'(q[0].pf));
      chk("d_pb",    64'(d_pb),      64'(q[0].pb));
      chk("d_comp",  64'(d_comp),    64'(q[0].instr[1:0] != 2'b11));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 64'(d_valid), 64'd0);
    chk({tag, "_ready"}, 64'(f_ready), 64'd1);
    chk({tag, "_pc"},    d_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_instr"}, 64'(d_instr), 64'hFFFF_FFFF);
    chk({tag, "_flags"}, 64'({d_lf, d_pf, d_pb}), 64'd0);
    chk({tag, "_comp"},  64'(d_comp), 64'd0);
  endtask

  // Advance one clock, update the model from the handshake rules, then compare.
  task automatic tick();
    bit   push;
    bit   pop;
    ent_t e;
    push = f_valid && (q.size() < DEPTH);
    pop  = d_ready && (q.size() > 0);
    e = '{pc: f_pc, instr: f_instr, lf: f_lf, pf: f_pf, pb: f_pb};
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single entry
    set_in(1'b1, 64'h1000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("single_pc", d_pc, 64'h1000);
    chk("single_comp", 64'(d_comp), 64'd0);
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("single_popped", 64'(d_valid), 64'd0);

    // Fill, full, ignored 5th word, ordered drain
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 64'h2000 + 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("full_ready", 64'(f_ready), 64'd0);
    set_in(1'b1, 64'h2010, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", d_pc, 64'h2000 + 64'(4 * i));
      set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("drain_empty", 64'(d_valid), 64'd0);

    // Push and pop together at count 2, then streaming across wrap
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 64'h5000 + 64'(4 * i), 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 64'h5008, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pp_head", d_pc, 64'h5004);
    chk("pp_count", 64'(q.size()), 64'd2);
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 64'h6000 + 64'(4 * i), 32'h0000_0093, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Flush with a concurrent push
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 64'h7000 + 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 64'h3000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("flush_valid", 64'(d_valid), 64'd0);
    chk("flush_ready", 64'(f_ready), 64'd1);
    set_in(1'b1, 64'h4000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_flush_pc", d_pc, 64'h4000);
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("post_flush_empty", 64'(d_valid), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), {$urandom, $urandom}, $urandom,
             1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(15) == 0));
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Compressed + faulted head, then asynchronous reset mid-stream
    set_in(1'b1, 64'h8000, 32'h0000_4501, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("flag_comp", 64'(d_comp), 64'd1);
    chk("flag_lf", 64'(d_lf), 64'd1);
    set_in(1'b1, 64'h8002, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check_reset("async_rst");
    set_in(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset("after_rst");
    set_in(1'b1, 64'h9000, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction queue between the fetch stage and the RISC-V instruction decoder. It buffers up to DEPTH fetched 32-bit instruction words together with their PC, fetch-fault flags and program-buffer flag. Entries are presented in order to the decoder with a valid/ready handshake. The queue decouples fetch latency from decode/execute stalls and is emptied in one cycle on a pipeline flush.

## Interface
Parameters:
- RISCV_ARCH, 64, PC width in bits.
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_nrst  in  1  reset; asynchronous, active-low.
- i_flush  in  1  discard all entries (branch mispredict, trap, fence.i).
- i_f_valid  in  1  fetch presents an entry.
- o_f_ready  out  1  queue accepts an entry this cycle.
- i_f_pc  in  RISCV_ARCH  PC of the fetched word.
- i_f_instr  in  32  fetched instruction word (compressed in [15:0]).
- i_f_load_fault  in  1  instruction access fault.
- i_f_page_fault_x  in  1  instruction page fault.
- i_f_progbuf_ena  in  1  word comes from the debug program buffer.
- o_d_valid  out  1  head entry valid for the decoder.
- i_d_ready  in  1  decoder consumes the head entry.
- o_d_pc  out  RISCV_ARCH  head PC.
- o_d_instr  out  32  head instruction word.
- o_d_load_fault  out  1  head access fault.
- o_d_page_fault_x  out  1  head page fault.
- o_d_progbuf_ena  out  1  head program-buffer flag.
- o_d_compressed  out  1  head word is compressed: o_d_instr[1:0] != 2'b11.

## Operation
- State:
  - storage array of DEPTH entries {pc, instr, load_fault, page_fault_x, progbuf_ena};
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Push = i_f_valid & o_f_ready. Pop = o_d_valid & i_d_ready.
- o_f_ready = (count != DEPTH).
  - It depends only on registered state, never on i_d_ready.
  - A full queue does not accept a word in the same cycle as a pop.
- o_d_valid = (count != 0).
- All o_d_* data outputs are driven combinationally from storage[rd_ptr].
- Push: storage[wr_ptr] is written, then wr_ptr+1.
- Pop: rd_ptr+1.
- Count update:
  - push only: count+1;
  - pop only: count-1;
  - push and pop together: count unchanged.
- Flush has priority over everything else. When i_flush=1:
  - wr_ptr, rd_ptr and count are set to 0 on the next edge;
  - any push or pop in that cycle is discarded;
  - storage contents are left unchanged.
- Fault and progbuf flags pass through unmodified. The queue never interprets them and never drops a faulted entry.
- The queue performs no decoding beyond o_d_compressed.

## Timing
- Reset (i_nrst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0;
  - every storage entry set to pc='1, instr='1, flags=0.
- Resulting reset outputs:
  - o_d_valid=0, o_f_ready=1;
  - o_d_pc='1, o_d_instr=32'hFFFF_FFFF;
  - o_d_load_fault=0, o_d_page_fault_x=0, o_d_progbuf_ena=0;
  - o_d_compressed=0.
- Latency: a word pushed at edge N is visible with o_d_valid=1 after edge N. There is no same-cycle bypass from i_f_* to o_d_*.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Empty queue: a pop is impossible because o_d_valid=0. i_d_ready is ignored.
- Full queue: o_f_ready=0, and i_f_valid is ignored.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble, and order is preserved.
- Flush:
  - o_d_valid=0 and o_f_ready=1 in the cycle after i_flush;
  - a new push is accepted in the cycle after i_flush.
- Reset asserted mid-operation: the state clears immediately (asynchronously). Pending entries are lost.

## Test plan
- Reset: hold i_nrst=0 -> o_d_valid=0, o_f_ready=1, o_d_pc=all ones, o_d_instr=FFFFFFFF, o_d_compressed=0.
- Single entry: push pc=0x1000, instr=0x00000013 with i_d_ready=0 -> next cycle o_d_valid=1, o_d_pc=0x1000, o_d_compressed=0. Then raise i_d_ready for one cycle -> o_d_valid=0.
- Fill/full: push 0x2000,0x2004,0x2008,0x200C with i_d_ready=0 -> o_f_ready=0 after the 4th push. A 5th word with i_f_valid=1 is ignored. Drain yields the PCs in order 0x2000..0x200C.
- Simultaneous push/pop at count=2 -> count stays 2. Run 10 pushes at 1 per cycle with continuous pop -> the output order matches the input order across pointer wrap.
- Flush: with 3 entries queued, assert i_flush together with a push of pc=0x3000 -> next cycle o_d_valid=0. Push pc=0x4000 -> next cycle o_d_pc=0x4000; 0x3000 never appears.
- Flags and compressed: push instr=0x00004501 with load_fault=1, then pull i_nrst low mid-stream -> the 0x00004501 head shows o_d_compressed=1 and o_d_load_fault=1. After the reset pulse, all reset values are restored.
